instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage of the core; sits directly upstream of immediate generation and decode.
//  Owns the PC, issues word reads to instruction memory over a req/gnt + rvalid handshake,
//  buffers returned words in a small FIFO and presents them to decode with valid/ready.
//  Exports instr[31:7] as the 25-bit immed field and, optionally, a predecoded 3-bit imm_ctrl.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH 2              instruction buffer entries; power of 2, >=2
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   synchronous reset, active low
//  imem_req       out  1   read request; address valid while high
//  imem_addr      out  32  word address of request, bits[1:0] always 0
//  imem_gnt       in   1   request accepted this cycle (req & gnt = handshake)
//  imem_rvalid    in   1   read data valid; exactly one per granted request, >=1 cycle after gnt
//  imem_rdata     in   32  instruction word
//  redirect_valid in   1   branch/jump/trap redirect, single-cycle pulse
//  redirect_pc    in   32  new PC; bits[1:0] ignored (forced 0)
//  dec_valid      out  1   dec_* hold a valid instruction
//  dec_ready      in   1   decode accepts (valid & ready = pop)
//  dec_instr      out  32  instruction word
//  dec_pc         out  32  PC of dec_instr
//  dec_immed      out  25  dec_instr[31:7], immediate-generation input
//  dec_imm_ctrl   out  3   immediate format select (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n low at edge): pc<=RESET_PC, FIFO empty, outstanding<=0, drop<=0; imem_req=0,
//   dec_valid=0, dec_instr/dec_pc/dec_immed/dec_imm_ctrl=0. First imem_req the cycle after release.
//  Reset mid-transaction: outstanding request abandoned; a later imem_rvalid for it is ignored (drop
//   state cleared by reset; memory is reset alongside).
//  FSM: IDLE -> REQ when credit; REQ holds req/addr until gnt -> WAIT; WAIT on rvalid -> REQ if credit
//   else IDLE. credit = (fifo_count + outstanding) < FIFO_DEPTH; at most one outstanding request.
//  On gnt: pc<=pc+4 (32-bit wrap 0xFFFF_FFFC -> 0x0), entry PC = granted addr travels with request.
//  On rvalid (not dropped): push {rdata, pc_of_req}. Push and pop same cycle on full FIFO is legal.
//  dec_* are driven from FIFO head (combinational read, zero added latency); dec_valid = !empty.
//  Fetch latency: reset release to first dec_valid = 2 + memory latency cycles (gnt same cycle).
//  Redirect (highest priority): FIFO flushed, pc<=redirect_pc&~3, dec_valid=0 next cycle.
//   - In REQ without gnt: request withdrawn; REQ reissued next cycle with new address.
//   - redirect & gnt same cycle: that request is in flight, marked drop; its rvalid discarded.
//   - In WAIT: drop<=1; returning data discarded, then REQ at redirect_pc.
//   - redirect & rvalid same cycle: data discarded, no push.
//   - redirect & dec_ready same cycle: pop is irrelevant, flush wins.
//  dec_* stable while dec_valid & !dec_ready (no redirect). Pop on empty FIFO is ignored.
// CONFIGURATION
//  IFETCH_PREDECODE_EN defined: imm_ctrl computed from opcode at push, stored in FIFO:
//   I(0000011,0010011,1100111,1110011)=0, S(0100011)=1, B(1100011)=2, U(0110111,0010111)=3,
//   J(1101111)=4, R-type/other=0.
//  IFETCH_PREDECODE_EN undefined: dec_imm_ctrl tied 3'd0, no storage; decode supplies imm_ctrl.
// TESTING
//  Reset, gnt=1, rvalid 1 cycle later, dec_ready=1 -> imem_addr 0,4,8,...; dec_pc matches, in order.
//  dec_ready=0 for 10 cycles -> exactly 2 words buffered, imem_req low, dec_* stable; release -> resume.
//  Redirect to 0x0000_0103 while in WAIT -> returning word dropped, next imem_addr 0x100, dec_pc 0x100.
//  Redirect same cycle as rvalid, FIFO holding 1 entry -> no push, dec_valid=0 next cycle.
//  With IFETCH_PREDECODE_EN: rdata 0x00000063 -> dec_imm_ctrl 2, dec_immed 25'h0; 0x0000006F -> 4.
//  gnt held low 5 cycles -> imem_req and imem_addr constant, pc not advanced.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches words over req/gnt/rvalid into a FIFO feeding decode.
// Optional predecode of the immediate format is enabled by defining IFETCH_PREDECODE_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  output logic [24:0] dec_immed_o,
  output logic [2:0]  dec_imm_ctrl_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e         st_q;
  logic           req_q, drop_q;
  logic [31:0]    pc_q, rpc_q;
  logic [31:0]    instr_q [FIFO_DEPTH];
  logic [31:0]    pcs_q [FIFO_DEPTH];
  logic [AW-1:0]  rd_q, wr_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic           empty, push, pop, credit;
`ifdef IFETCH_PREDECODE_EN
  logic [2:0]     ctrl_q [FIFO_DEPTH];
  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    return op == 7'b0100011 ? 3'd1 :
           op == 7'b1100011 ? 3'd2 :
           (op == 7'b0110111 || op == 7'b0010111) ? 3'd3 :
           op == 7'b1101111 ? 3'd4 : 3'd0;
  endfunction
`endif
  // FIFO occupancy bookkeeping; a redirect flushes and suppresses both push and pop
  always_comb begin
    empty  = cnt_q == '0;
    push   = st_q == WAIT && imem_rvalid_i && !drop_q && !redirect_valid_i;
    pop    = !empty && dec_ready_i && !redirect_valid_i;
    cnt_d  = redirect_valid_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    credit = cnt_d < (AW+1)'(FIFO_DEPTH);
  end
  // Fetch FSM: one request in flight at most; redirect overrides everything
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= IDLE;
      req_q  <= 1'b0;
      drop_q <= 1'b0;
      pc_q   <= RESET_PC;
      rpc_q  <= '0;
    end else if (redirect_valid_i) begin
      pc_q <= redirect_pc_i & ~32'h3;
      if ((st_q == REQ && imem_gnt_i) || (st_q == WAIT && !imem_rvalid_i)) begin
        st_q   <= WAIT;
        req_q  <= 1'b0;
        drop_q <= 1'b1;
      end else begin
        st_q   <= REQ;
        req_q  <= 1'b1;
        drop_q <= 1'b0;
      end
    end else begin
      case (st_q)
        IDLE: if (credit) begin
          st_q  <= REQ;
          req_q <= 1'b1;
        end
        REQ: if (imem_gnt_i) begin
          st_q  <= WAIT;
          req_q <= 1'b0;
          pc_q  <= pc_q + 32'd4;
          rpc_q <= pc_q;
        end
        WAIT: if (imem_rvalid_i) begin
          drop_q <= 1'b0;
          st_q   <= credit ? REQ : IDLE;
          req_q  <= credit;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  // FIFO pointers and count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= redirect_valid_i ? '0 : rd_q + AW'(pop);
      wr_q  <= redirect_valid_i ? '0 : wr_q + AW'(push);
    end
  end
  // FIFO storage: word, its PC and optionally the predecoded immediate format
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_q] <= imem_rdata_i;
      pcs_q[wr_q]   <= rpc_q;
`ifdef IFETCH_PREDECODE_EN
      ctrl_q[wr_q]  <= imm_fmt(imem_rdata_i[6:0]);
`endif
    end
  end
  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign dec_valid_o = !empty;
  assign dec_instr_o = empty ? '0 : instr_q[rd_q];
  assign dec_pc_o    = empty ? '0 : pcs_q[rd_q];
  assign dec_immed_o = dec_instr_o[31:7];
`ifdef IFETCH_PREDECODE_EN
  assign dec_imm_ctrl_o = empty ? 3'd0 : ctrl_q[rd_q];
`else
  assign dec_imm_ctrl_o = 3'd0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized memory/decode environment with a program-order scoreboard.
module tb_instr_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect_valid = 1'b0, dec_valid, dec_ready = 1'b0;
  logic [31:0] redirect_pc = '0, dec_instr, dec_pc;
  logic [24:0] dec_immed;
  logic [2:0]  dec_imm_ctrl;
  int n_chk = 0, n_fail = 0, n_pop = 0, cyc = 0;
  int gnt_mode = 0, lat_min = 1, lat_max = 1;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [31:0] addr; int due;} req_t;
  ent_t exp_q[$];
  req_t pend[$];
  logic [31:0] exp_next;
  logic pv = 1'b0, pr = 1'b0, pred = 1'b0, prst = 1'b0;
  logic [31:0] ppc = '0, pin = '0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .dec_instr_o(dec_instr), .dec_pc_o(dec_pc),
    .dec_immed_o(dec_immed), .dec_imm_ctrl_o(dec_imm_ctrl)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (a == 32'h200) return 32'h0000_0063;
    if (a == 32'h204) return 32'h0000_006F;
    h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    case ((a >> 2) % 10)
      0: op = 7'b0000011;
      1: op = 7'b0010011;
      2: op = 7'b1100111;
      3: op = 7'b1110011;
      4: op = 7'b0100011;
      5: op = 7'b1100011;
      6: op = 7'b0110111;
      7: op = 7'b0010111;
      8: op = 7'b1101111;
      default: op = 7'b0110011;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic [2:0] ref_ctrl(input logic [31:0] w);
`ifdef IFETCH_PREDECODE_EN
    case (w[6:0])
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111:             return 3'd4;
      default:                return 3'd0;
    endcase
`else
    return w[2:0] & 3'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{exp_next, mem_word(exp_next)});
      exp_next += 32'd4;
    end
  endtask

  task automatic expect_from(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc;
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Instruction memory: grants per gnt_mode, one in-order rvalid per grant after lat cycles
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) pend.delete();
      else begin
        if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
        if (imem_req && imem_gnt) begin
          check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
          pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        end
      end
      @(posedge clk);
      #1;
      imem_gnt    = (gnt_mode == 0) || (gnt_mode == 1 && $urandom_range(1, 0) == 1);
      imem_rvalid = pend.size() > 0 && pend[0].due <= cyc + 1;
      imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : $urandom;
    end
  end

  // Monitor: pops the scoreboard on every decode handshake and watches flush/hold rules
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pred) check("flush_after_redirect", {31'b0, dec_valid}, 32'h0);
      if (rst_n && prst && pv && !pr && !pred) begin
        check("hold_valid", {31'b0, dec_valid}, 32'h1);
        check("hold_pc", dec_pc, ppc);
        check("hold_instr", dec_instr, pin);
      end
      if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_empty: got pc %h expected none", dec_pc);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("dec_pc", dec_pc, e.pc);
          check("dec_instr", dec_instr, e.instr);
          check("dec_immed", {7'b0, dec_immed}, {7'b0, e.instr[31:7]});
          check("dec_imm_ctrl", {29'b0, dec_imm_ctrl}, {29'b0, ref_ctrl(e.instr)});
        end
      end
      pv = dec_valid; pr = dec_ready; pred = redirect_valid; prst = rst_n;
      ppc = dec_pc; pin = dec_instr;
    end
  end

  // Stimulus: directed scenarios then a randomized run
  initial begin
    int c;
    logic [31:0] held;
    expect_from(32'h0);
    repeat (3) step();
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_instr", dec_instr, 32'h0);
    check("rst_pc", dec_pc, 32'h0);
    check("rst_immed", {7'b0, dec_immed}, 32'h0);
    check("rst_ctrl", {29'b0, dec_imm_ctrl}, 32'h0);
    step();
    rst_n = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req) break;
      step();
    end
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    repeat (20) step();
    dec_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("stall_req_low", {31'b0, imem_req}, 32'h0);
    check("stall_valid", {31'b0, dec_valid}, 32'h1);
    step();
    gnt_mode = 2;
    dec_ready = 1'b1;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dec_valid) c++;
      step();
    end
    check("stall_buffered", c, 32'd2);
    @(negedge clk);
    held = imem_addr;
    check("gnt_low_addr", held, exp_q[0].pc);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("gnt_low_req", {31'b0, imem_req}, 32'h1);
      check("gnt_low_hold", imem_addr, held);
    end
    step();
    gnt_mode = 0;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) break;
      step();
    end
    check("wait_hs_seen", {31'b0, imem_req & imem_gnt}, 32'h1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    expect_from(32'h100);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) break;
      step();
    end
    check("redir_wait_addr", imem_addr, 32'h100);
    repeat (10) step();
    lat_min = 2;
    lat_max = 2;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    expect_from(32'h300);
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      if (imem_rvalid && dec_valid) break;
    end
    check("rv_one_entry_seen", {31'b0, imem_rvalid & dec_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h340;
    expect_from(32'h340);
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    check("rv_redirect_flush", {31'b0, dec_valid}, 32'h0);
    step();
    lat_min = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    expect_from(32'h200);
    step();
    redirect_valid = 1'b0;
    repeat (15) step();
    gnt_mode = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      step();
      redirect_valid = 1'b0;
      dec_ready = $urandom_range(3, 0) != 0;
      if (i == 700) begin
        rst_n = 1'b0;
        expect_from(32'h0);
      end else if (i == 702) rst_n = 1'b1;
      else if (rst_n && $urandom_range(19, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFF);
        expect_from(redirect_pc & ~32'h3);
      end
    end
    step();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    gnt_mode = 0;
    repeat (30) step();
    check("progress", {31'b0, n_pop > 100}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
